// File: rtl/lin_pkg.sv
// Shared LIN definitions: response FSM states, idle frame pattern,
// event-triggered frame ID and byte framing / checksum helpers.
package lin_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_RDWAIT,
    ST_SEND,
    ST_CHKSUM
  } lin_state_t;

  localparam logic [9:0] LIN_FRAME_IDLE = 10'h3FF;
  localparam logic [5:0] EVT_PID        = 6'h22;

  // UART character: stop bit high, data, start bit low.
  function automatic logic [9:0] lin_frame(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  // 8-bit add with end-around carry; cannot overflow a second time.
  function automatic logic [7:0] chk_add(input logic [7:0] sum, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, sum} + {1'b0, b};
    return s[7:0] + {7'd0, s[8]};
  endfunction

endpackage

// File: rtl/lin_chksum_acc.sv
// LIN checksum accumulator: load a seed, then fold in one byte per add strobe.
module lin_chksum_acc
  import lin_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       init,
  input  logic [7:0] seed,
  input  logic       add,
  input  logic [7:0] data,
  output logic [7:0] sum
);

  always_ff @(posedge clk) begin
    if (reset)     sum <= 8'h00;
    else if (init) sum <= seed;
    else if (add)  sum <= chk_add(sum, data);
  end

endmodule

// File: rtl/lin_resp_publisher_p.sv
// LIN slave-publisher response engine: fetches response data from memory or the
// status register, frames it for the UART and appends the LIN checksum.
module lin_resp_publisher_p
  import lin_pkg::*;
#(
  parameter int unsigned MAX_BYTES = 8,
  parameter int unsigned MEM_W     = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter logic [5:0]  EVT_PID   = lin_pkg::EVT_PID
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        pid,
  input  logic [3:0]        dlen,
  input  logic              enhanced,
  input  logic              status_sel,
  input  logic [7:0]        status_byte,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              abort,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [MEM_W-1:0]  mem_rdata,
  output logic [9:0]        tx_byte,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic              skipped,
  output logic              err
);

  localparam int unsigned BPW    = MEM_W / 8;
  localparam int unsigned NWORDS = (MAX_BYTES + BPW - 1) / BPW;
  localparam int unsigned NBYTES = NWORDS * BPW;

  typedef logic [NBYTES-1:0][7:0] byte_buf_t;

  lin_state_t state;
  logic [3:0] len, byte_idx, word_idx;
  logic       is_evt, status_mode;
  byte_buf_t  buffer, shadow, cand;
  logic [3:0] shadow_len, cmp_len, words_needed;
  logic       shadow_valid, shadow_eq;
  logic       dlen_ok, evt_in, word_end, last_byte, more_words;
  logic [7:0] cur_byte, nxt_byte, sum;
  logic       acc_init, acc_add;

  function automatic logic [7:0] pick(input byte_buf_t v, input logic [3:0] i);
    logic [7:0] r;
    r = 8'h00;
    for (int k = 0; k < int'(NBYTES); k++)
      if (i == 4'(k)) r = v[k];
    return r;
  endfunction

  assign dlen_ok      = (dlen != 4'd0) && (dlen <= 4'(MAX_BYTES));
  assign evt_in       = (pid[5:0] == EVT_PID);
  assign words_needed = 4'((int'(len) + int'(BPW) - 1) / int'(BPW));
  assign more_words   = (word_idx + 4'd1) < words_needed;
  assign cur_byte     = pick(buffer, byte_idx);
  assign nxt_byte     = pick(buffer, byte_idx + 4'd1);
  assign last_byte    = (byte_idx + 4'd1) == len;
  assign word_end     = ((int'(byte_idx) + 1) % int'(BPW)) == 0;
  assign cmp_len      = (state == ST_IDLE) ? dlen : len;

  // Buffer contents as they will be after this cycle's capture.
  always_comb begin
    cand = buffer;
    if (state == ST_IDLE) begin
      for (int k = 0; k < int'(NBYTES); k++) cand[k] = status_byte;
    end else if (state == ST_RDWAIT) begin
      for (int k = 0; k < int'(NBYTES); k++)
        if (4'(k / int'(BPW)) == word_idx) cand[k] = mem_rdata[(k % int'(BPW))*8 +: 8];
    end
  end

  always_comb begin
    shadow_eq = shadow_valid && (shadow_len == cmp_len);
    for (int k = 0; k < int'(NBYTES); k++)
      if ((4'(k) < cmp_len) && (cand[k] != shadow[k])) shadow_eq = 1'b0;
  end

  assign acc_init = (state == ST_IDLE) && start && dlen_ok;
  assign acc_add  = (state == ST_SEND) && tx_ready && !abort;

  lin_chksum_acc u_chksum (
    .clk   (clk),
    .reset (reset),
    .init  (acc_init),
    .seed  (enhanced ? pid : 8'h00),
    .add   (acc_add),
    .data  (cur_byte),
    .sum   (sum)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      tx_valid     <= 1'b0;
      mem_rd       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      skipped      <= 1'b0;
      err          <= 1'b0;
      tx_byte      <= LIN_FRAME_IDLE;
      mem_addr     <= '0;
      len          <= 4'd0;
      byte_idx     <= 4'd0;
      word_idx     <= 4'd0;
      is_evt       <= 1'b0;
      status_mode  <= 1'b0;
      buffer       <= '0;
      shadow       <= '0;
      shadow_len   <= 4'd0;
      shadow_valid <= 1'b0;
    end else begin
      done    <= 1'b0;
      skipped <= 1'b0;
      err     <= 1'b0;
      if (abort && (state != ST_IDLE)) begin
        state    <= ST_IDLE;
        busy     <= 1'b0;
        tx_valid <= 1'b0;
        mem_rd   <= 1'b0;
        tx_byte  <= LIN_FRAME_IDLE;
        err      <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: if (start) begin
            if (!dlen_ok) begin
              err <= 1'b1;
            end else begin
              len         <= dlen;
              is_evt      <= evt_in;
              status_mode <= status_sel;
              byte_idx    <= 4'd0;
              word_idx    <= 4'd0;
              if (status_sel) begin
                buffer <= cand;
                if (evt_in && shadow_eq) begin
                  done    <= 1'b1;
                  skipped <= 1'b1;
                end else begin
                  state    <= ST_SEND;
                  busy     <= 1'b1;
                  tx_valid <= 1'b1;
                  tx_byte  <= lin_frame(status_byte);
                end
              end else begin
                state    <= ST_FETCH;
                busy     <= 1'b1;
                mem_rd   <= 1'b1;
                mem_addr <= start_addr;
              end
            end
          end
          ST_FETCH: begin
            mem_rd <= 1'b0;
            state  <= ST_RDWAIT;
          end
          ST_RDWAIT: begin
            buffer   <= cand;
            word_idx <= word_idx + 4'd1;
            // Event frames gather the whole response before deciding to send.
            if (is_evt && more_words) begin
              state    <= ST_FETCH;
              mem_rd   <= 1'b1;
              mem_addr <= mem_addr + ADDR_W'(1);
            end else if (is_evt && shadow_eq) begin
              state   <= ST_IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
              skipped <= 1'b1;
            end else begin
              state    <= ST_SEND;
              tx_valid <= 1'b1;
              tx_byte  <= lin_frame(pick(cand, byte_idx));
            end
          end
          ST_SEND: if (tx_ready) begin
            byte_idx <= byte_idx + 4'd1;
            if (last_byte) begin
              state   <= ST_CHKSUM;
              tx_byte <= lin_frame(~chk_add(sum, cur_byte));
            end else if (!is_evt && !status_mode && word_end) begin
              state    <= ST_FETCH;
              tx_valid <= 1'b0;
              tx_byte  <= LIN_FRAME_IDLE;
              mem_rd   <= 1'b1;
              mem_addr <= mem_addr + ADDR_W'(1);
            end else begin
              tx_byte <= lin_frame(nxt_byte);
            end
          end
          ST_CHKSUM: if (tx_ready) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            tx_valid <= 1'b0;
            tx_byte  <= LIN_FRAME_IDLE;
            done     <= 1'b1;
            if (is_evt) begin
              shadow       <= buffer;
              shadow_len   <= len;
              shadow_valid <= 1'b1;
            end
          end
          default: begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            tx_valid <= 1'b0;
            mem_rd   <= 1'b0;
            tx_byte  <= LIN_FRAME_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lin_resp_publisher_p.sv
// Directed bench for lin_resp_publisher_p: table of response frames plus
// hand-written abort, error, backpressure and reset sequences.
module tb_lin_resp_publisher_p;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, enhanced, status_sel, abort, tx_ready;
  logic [7:0]  pid, status_byte;
  logic [3:0]  dlen;
  logic [31:0] start_addr, mem_addr, mem_rdata;
  logic        mem_rd, tx_valid, busy, done, skipped, err;
  logic [9:0]  tx_byte;

  int pass_cnt = 0;
  int total    = 0;

  lin_resp_publisher_p dut (
    .clk(clk), .reset(reset), .start(start), .pid(pid), .dlen(dlen),
    .enhanced(enhanced), .status_sel(status_sel), .status_byte(status_byte),
    .start_addr(start_addr), .abort(abort), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .tx_byte(tx_byte), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .done(done), .skipped(skipped), .err(err)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:15];
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr[3:0]];

  typedef struct {
    logic        enh;
    logic        ssel;
    logic [7:0]  sbyte;
    logic [7:0]  pid;
    logic [3:0]  dlen;
    logic [31:0] addr;
    logic [63:0] data;   // byte k at [8k+:8]
    logic [7:0]  chk;
    int          lat;    // -1: tx_valid never rises
    logic        skip;
    logic        rnd;
  } vec_t;

  vec_t vecs [0:10];

  function automatic logic [9:0] frm(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  task automatic check(input string name, input int act, input int exp_v);
    total++;
    if (act == exp_v) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
  endtask

  task automatic run_vec(input int vi, input vec_t v);
    logic [9:0] got [0:15];
    logic [9:0] prev_byte;
    int first, ng, unstable;
    logic done_seen, skip_seen, memrd_seen, prev_hold;
    @(negedge clk);
    enhanced = v.enh; status_sel = v.ssel; status_byte = v.sbyte; pid = v.pid;
    dlen = v.dlen; start_addr = v.addr; tx_ready = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    first = -1; ng = 0; unstable = 0; prev_byte = '0;
    done_seen = 0; skip_seen = 0; memrd_seen = 0; prev_hold = 0;
    for (int cyc = 1; cyc <= 200 && !done_seen; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (mem_rd) memrd_seen = 1;
      if (prev_hold && tx_byte != prev_byte) unstable++;
      if (tx_valid && first < 0) first = cyc;
      if (done) begin done_seen = 1; skip_seen = skipped; end
      tx_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tx_valid && tx_ready) begin
        if (ng < 16) got[ng] = tx_byte;
        ng++;
      end
      prev_hold = tx_valid && !tx_ready;
      prev_byte = tx_byte;
    end
    tx_ready = 1'b0;
    check($sformatf("v%0d_done", vi), int'(done_seen), 1);
    check($sformatf("v%0d_skipped", vi), int'(skip_seen), int'(v.skip));
    check($sformatf("v%0d_latency", vi), first, v.lat);
    check($sformatf("v%0d_nbytes", vi), ng, v.skip ? 0 : int'(v.dlen) + 1);
    check($sformatf("v%0d_memrd", vi), int'(memrd_seen), int'(!v.ssel));
    check($sformatf("v%0d_stable", vi), unstable, 0);
    if (!v.skip && ng == int'(v.dlen) + 1) begin
      for (int k = 0; k < int'(v.dlen); k++)
        check($sformatf("v%0d_byte%0d", vi, k), int'(got[k]), int'(frm(v.data[8*k +: 8])));
      check($sformatf("v%0d_chk", vi), int'(got[v.dlen]), int'(frm(v.chk)));
    end
  endtask

  initial begin
    int acc;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[0] = 32'h04030201; mem[1] = 32'h08070605; mem[2] = 32'h000001FF;
    mem[4] = 32'h00332211; mem[5] = 32'h00332299; mem[6] = 32'hDEADBEEF;
    mem[7] = 32'h44332211; mem[8] = 32'h00006655;

    //          enh  ssel sbyte  pid    dlen  addr data                    chk    lat skip rnd
    vecs[0]  = '{1'b0, 1'b0, 8'h00, 8'h10, 4'd8, 0, 64'h0807060504030201, 8'hDB, 3, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 8'h00, 8'h42, 4'd2, 2, 64'h01FF,             8'hBC, 3, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 8'h5A, 8'h10, 4'd4, 0, 64'h5A5A5A5A,         8'h96, 1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 8'h10, 4'd5, 0, 64'h0504030201,       8'hF0, 3, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 8'h00, 8'h80, 4'd8, 0, 64'h0807060504030201, 8'h5B, 3, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 8'h10, 4'd1, 6, 64'hEF,               8'h10, 3, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 8'hA2, 4'd3, 4, 64'h332211,           8'h99, 3, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 8'hA2, 4'd3, 4, 64'h332211,           8'h00, -1, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 8'hA2, 4'd3, 5, 64'h332299,           8'h11, 3, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 8'hA2, 4'd6, 7, 64'h665544332211,     8'h99, 5, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 8'hA2, 4'd6, 7, 64'h665544332211,     8'h00, -1, 1'b1, 1'b0};

    reset = 1'b1; start = 0; abort = 0; tx_ready = 0; enhanced = 0; status_sel = 0;
    pid = 0; dlen = 0; status_byte = 0; start_addr = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_tx_byte", int'(tx_byte), 32'h3FF);
    check("rst_tx_valid", int'(tx_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_mem_rd", int'(mem_rd), 0);
    check("rst_mem_addr", int'(mem_addr), 0);
    check("rst_done_err", int'({done, skipped, err}), 0);

    for (int i = 0; i <= 10; i++) run_vec(i, vecs[i]);

    // Bad lengths are rejected from IDLE.
    @(negedge clk); dlen = 4'd0; status_sel = 0; start = 1;
    @(negedge clk); start = 0;
    check("dlen0_err", int'(err), 1);
    check("dlen0_busy", int'(busy), 0);
    @(negedge clk);
    check("dlen0_err_pulse", int'(err), 0);
    dlen = 4'd9; start = 1;
    @(negedge clk); start = 0;
    check("dlen9_err", int'(err), 1);
    check("dlen9_busy", int'(busy), 0);

    // Abort in IDLE is ignored.
    @(negedge clk); abort = 1;
    @(negedge clk); abort = 0;
    check("idle_abort_err", int'(err), 0);
    check("idle_abort_busy", int'(busy), 0);

    // Start while busy is ignored; abort after the third byte.
    @(negedge clk);
    enhanced = 0; status_sel = 0; pid = 8'h10; dlen = 4'd8; start_addr = 0; start = 1;
    @(negedge clk); start = 0;
    check("busy_after_start", int'(busy), 1);
    dlen = 4'd0; start = 1;
    @(negedge clk); start = 0;
    check("start_busy_no_err", int'(err), 0);
    tx_ready = 1; acc = 0;
    for (int cyc = 0; cyc < 50 && acc < 3; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (tx_valid && tx_ready) acc++;
    end
    check("abort_reach_3", acc, 3);
    @(negedge clk); tx_ready = 0; abort = 1;
    check("abort_pre_valid", int'(tx_valid), 1);
    @(negedge clk); abort = 0;
    check("abort_err", int'(err), 1);
    check("abort_tx_valid", int'(tx_valid), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_tx_byte", int'(tx_byte), 32'h3FF);
    @(negedge clk);
    check("abort_err_pulse", int'(err), 0);

    // Start and abort together in IDLE: start wins; then stall and reset mid-frame.
    status_sel = 1; status_byte = 8'h3C; dlen = 4'd1; pid = 8'h10; start = 1; abort = 1;
    @(negedge clk); start = 0; abort = 0;
    check("start_wins_busy", int'(busy), 1);
    check("start_wins_valid", int'(tx_valid), 1);
    check("start_wins_byte", int'(tx_byte), int'(frm(8'h3C)));
    repeat (20) @(negedge clk);
    check("stall_valid", int'(tx_valid), 1);
    check("stall_byte", int'(tx_byte), int'(frm(8'h3C)));
    check("stall_no_done", int'(done), 0);
    reset = 1;
    @(negedge clk); reset = 0;
    check("midrst_busy", int'(busy), 0);
    check("midrst_valid", int'(tx_valid), 0);
    check("midrst_byte", int'(tx_byte), 32'h3FF);

    // Shadow was cleared by reset: the event frame is published again.
    run_vec(6, vecs[6]);
    run_vec(0, vecs[0]);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
